// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_feeder
//  Description : Parallel-to-serial feeder for the 2-bit Mealy sequence
//                detector. Accepts WIDTH-bit words on a valid/ready handshake
//                and emits them one bit per clock on x_out, with a
//                configurable bit order and an idle gap between words.
//  Optional    : define SERIAL_BIT_FEEDER_PARITY_EN to append an even-parity
//                bit after the data bits of every word.
//  Ports       : clk       - system clock, rising edge
//                rst       - asynchronous reset, active low
//                din       - parallel word to serialize
//                din_valid - din holds a word
//                din_ready - a word can be accepted this cycle
//                x_out     - serial bit to the detector (registered)
//                x_valid   - x_out carries a data/parity bit (registered)
//                busy      - feeder is shifting or in the inter-word gap
//                done      - high while the final bit of a word is on x_out
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_feeder #(
   parameter int   WIDTH      = 8,
   parameter int   MSB_FIRST  = 1,
   parameter int   GAP        = 0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
   localparam int N_BITS = WIDTH + 1;
`else
   localparam int N_BITS = WIDTH;
`endif
   localparam int               CNT_W    = $clog2(N_BITS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BITS - 1);
   // Only meaningful when GAP > 0; the GAP state is unreachable otherwise.
   localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [3:0]       gap_q,   gap_d;
   logic             x_out_q, x_out_d;
   logic             x_valid_q, x_valid_d;
   logic             done_q,  done_d;

   logic             take;
   logic             on_last;
   logic             first_bit;
   logic             next_data;
   logic             next_bit;
   logic [WIDTH-1:0] load_rest;
   logic [WIDTH-1:0] shift_rest;

   // The first bit goes straight to x_out on the transfer edge, so the shift
   // register is loaded with the remaining bits already advanced by one.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign first_bit  = din[WIDTH-1];
         assign load_rest  = {din[WIDTH-2:0], 1'b0};
         assign next_data  = shift_q[WIDTH-1];
         assign shift_rest = {shift_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign first_bit  = din[0];
         assign load_rest  = {1'b0, din[WIDTH-1:1]};
         assign next_data  = shift_q[0];
         assign shift_rest = {1'b0, shift_q[WIDTH-1:1]};
      end
   endgenerate

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (take) begin
         parity_d = ^din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   // Once the last data bit is on x_out the next bit time carries parity.
   assign next_bit = (cnt_q == CNT_W'(WIDTH - 1)) ? parity_q : next_data;
`else
   assign next_bit = next_data;
`endif

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      x_out_d   = IDLE_LEVEL;
      x_valid_d = 1'b0;
      done_d    = 1'b0;

      // cnt_q is the index of the bit currently on x_out.
      on_last   = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
      // Gated by rst so nothing can be offered while reset is held.
      din_ready = rst && ((state_q == ST_IDLE) || (on_last && (GAP == 0)));
      take      = din_valid && din_ready;

      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d   = ST_SHIFT;
               shift_d   = load_rest;
               cnt_d     = '0;
               x_out_d   = first_bit;
               x_valid_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (!on_last) begin
               shift_d   = shift_rest;
               cnt_d     = cnt_q + CNT_W'(1);
               x_out_d   = next_bit;
               x_valid_d = 1'b1;
               done_d    = ((cnt_q + CNT_W'(1)) == LAST_IDX);
            end else if (GAP != 0) begin
               state_d = ST_GAP;
               gap_d   = '0;
            end else if (take) begin
               // Back-to-back reload: no idle bit between words.
               shift_d   = load_rest;
               cnt_d     = '0;
               x_out_d   = first_bit;
               x_valid_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         x_out_q   <= IDLE_LEVEL;
         x_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         x_out_q   <= x_out_d;
         x_valid_q <= x_valid_d;
         done_q    <= done_d;
      end
   end

   assign x_out   = x_out_q;
   assign x_valid = x_valid_q;
   assign done    = done_q;
   assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_bit_feeder
//  Description : Self-checking bench for serial_bit_feeder. Three instances
//                with different bit order / gap / idle level / width are
//                compared every cycle against a schedule model: each accepted
//                word appends its expected bit times (and gap bit times) to a
//                per-instance list, and each clock consumes one entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bit_feeder;

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] din_a [3];
   logic [2:0]  dv;
   logic [2:0]  rd, xo, xv, by, dn;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP(0), .IDLE_LEVEL(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .din(din_a[0][7:0]), .din_valid(dv[0]), .din_ready(rd[0]),
      .x_out(xo[0]), .x_valid(xv[0]), .busy(by[0]), .done(dn[0]));

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .GAP(2), .IDLE_LEVEL(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .din(din_a[1][7:0]), .din_valid(dv[1]), .din_ready(rd[1]),
      .x_out(xo[1]), .x_valid(xv[1]), .busy(by[1]), .done(dn[1]));

   serial_bit_feeder #(.WIDTH(5), .MSB_FIRST(1), .GAP(1), .IDLE_LEVEL(1'b1)) u_dut2 (
      .clk(clk), .rst(rst), .din(din_a[2][4:0]), .din_valid(dv[2]), .din_ready(rd[2]),
      .x_out(xo[2]), .x_valid(xv[2]), .busy(by[2]), .done(dn[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int w_of(int i);   return (i == 2) ? 5 : 8;                 endfunction
   function automatic int msb_of(int i); return (i == 1) ? 0 : 1;                 endfunction
   function automatic int gap_of(int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
   function automatic logic idle_of(int i); return (i == 2);                      endfunction

   // ---------------- schedule model ----------------
   // entry = {done, valid, bit}; entry 0 is what must be visible this cycle
   logic [2:0] sched [3][32];
   int         mcnt  [3] = '{0, 0, 0};

   function automatic logic m_ready(int i);
      return (rst === 1'b1) && ((mcnt[i] == 0) || ((mcnt[i] == 1) && sched[i][0][2]));
   endfunction

   task automatic push_word(int i, logic [31:0] w);
      int          wd;
      int          n;
      logic [31:0] msk;
      logic        b;
      wd  = w_of(i);
      n   = wd + PAR;
      msk = 32'((64'd1 << wd) - 64'd1);
      for (int j = 0; j < n; j++) begin
         if (j == wd) b = ^(w & msk);
         else         b = (msb_of(i) != 0) ? w[wd-1-j] : w[j];
         sched[i][mcnt[i]] = {(j == n - 1), 1'b1, b};
         mcnt[i]++;
      end
      for (int j = 0; j < gap_of(i); j++) begin
         sched[i][mcnt[i]] = {1'b0, 1'b0, idle_of(i)};
         mcnt[i]++;
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (rst !== 1'b1) begin
         for (int i = 0; i < 3; i++) mcnt[i] = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            logic tk;
            tk = dv[i] && m_ready(i);
            if (mcnt[i] > 0) begin
               for (int k = 0; k < 31; k++) sched[i][k] = sched[i][k+1];
               mcnt[i]--;
            end
            if (tk) push_word(i, din_a[i]);
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input int inst, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h (cycle %0d)", name, inst, act, exp, cyc);
      end
   endtask

   // stream capture used by the hand-computed checks
   logic [63:0] cap    [3];
   int          ncap   [3];
   int          ndone  [3];
   int          nbusy  [3];
   int          maxbub [3];
   int          lastv  [3];

   task automatic clear_cap();
      for (int i = 0; i < 3; i++) begin
         cap[i] = '0; ncap[i] = 0; ndone[i] = 0; nbusy[i] = 0; maxbub[i] = 0; lastv[i] = -1;
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
         logic [2:0] e;
         e = (mcnt[i] > 0) ? sched[i][0] : {1'b0, 1'b0, idle_of(i)};
         check("x_out",     i, 64'(xo[i]), 64'(e[0]));
         check("x_valid",   i, 64'(xv[i]), 64'(e[1]));
         check("done",      i, 64'(dn[i]), 64'(e[2]));
         check("busy",      i, 64'(by[i]), 64'(mcnt[i] > 0));
         check("din_ready", i, 64'(rd[i]), 64'(m_ready(i)));
         if (xv[i] === 1'b1) begin
            cap[i] = {cap[i][62:0], xo[i]};
            ncap[i]++;
            if (lastv[i] >= 0 && (cyc - lastv[i] - 1) > maxbub[i]) maxbub[i] = cyc - lastv[i] - 1;
            lastv[i] = cyc;
         end
         if (dn[i] === 1'b1) ndone[i]++;
         if (by[i] === 1'b1) nbusy[i]++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   localparam int N8 = 8 + PAR;

   initial begin
      clear_cap();
      rst = 1'b0;
      dv  = 3'b111;
      for (int i = 0; i < 3; i++) din_a[i] = $urandom;
      tick(2);
      rst = 1'b1;                      // first transfer on the next edge
      tick(1);
      dv = 3'b000;
      tick(16);
      check("post_reset_words", 0, 64'(ncap[0]), 64'(N8));

      // single word, MSB first
      clear_cap();
      din_a[0] = 32'hA5; dv[0] = 1'b1;
      tick(1);
      dv[0] = 1'b0;
      tick(N8 + 2);
      check("a5_stream", 0, cap[0], (PAR != 0) ? 64'({8'hA5, 1'b0}) : 64'(8'hA5));
      check("a5_bits",   0, 64'(ncap[0]), 64'(N8));
      check("a5_done",   0, 64'(ndone[0]), 64'd1);

      // single word, LSB first, gap of 2 on instance 1
      clear_cap();
      din_a[1] = 32'h01; dv[1] = 1'b1;
      tick(1);
      dv[1] = 1'b0;
      tick(N8 + 4);
      check("lsb_stream", 1, cap[1], (PAR != 0) ? 64'({8'h80, 1'b1}) : 64'(8'h80));
      check("lsb_busy",   1, 64'(nbusy[1]), 64'(N8 + 2));

      // back-to-back with din_valid held
      clear_cap();
      din_a[0] = 32'h0F; dv[0] = 1'b1;
      tick(1);
      din_a[0] = 32'hF0;
      tick(N8);
      dv[0] = 1'b0;
      tick(N8 + 2);
      check("b2b_stream", 0, cap[0],
            (PAR != 0) ? 64'({8'h0F, 1'b0, 8'hF0, 1'b0}) : 64'(16'h0FF0));
      check("b2b_bits",   0, 64'(ncap[0]), 64'(2 * N8));
      check("b2b_done",   0, 64'(ndone[0]), 64'd2);
      check("b2b_bubble", 0, 64'(maxbub[0]), 64'd0);

      // gap of 2: two words queued; gap plus one idle cycle between them
      clear_cap();
      din_a[1] = 32'h3C; dv[1] = 1'b1;
      tick(1);
      din_a[1] = 32'hC3;
      tick(N8 + 3);
      dv[1] = 1'b0;
      tick(N8 + 4);
      check("gap_bits",   1, 64'(ncap[1]), 64'(2 * N8));
      check("gap_bubble", 1, 64'(maxbub[1]), 64'd3);

      // reset in the middle of a word
      din_a[0] = 32'hFF; dv[0] = 1'b1;
      tick(1);
      dv[0] = 1'b0;
      tick(3);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 0, 64'(xv[0]), 64'd0);
      check("mid_rst_busy",  0, 64'(by[0]), 64'd0);
      tick(1);
      rst = 1'b1;
      clear_cap();
      din_a[0] = 32'h80; dv[0] = 1'b1;
      tick(1);
      dv[0] = 1'b0;
      tick(N8 + 2);
      check("rst_80_stream", 0, cap[0], (PAR != 0) ? 64'({8'h80, 1'b1}) : 64'(8'h80));

      // parity sample word (odd number of ones)
      clear_cap();
      din_a[0] = 32'h07; dv[0] = 1'b1;
      tick(1);
      dv[0] = 1'b0;
      tick(N8 + 2);
      check("w07_stream", 0, cap[0], (PAR != 0) ? 64'({8'h07, 1'b1}) : 64'(8'h07));
      check("w07_bits",   0, 64'(ncap[0]), 64'(N8));

      // randomized traffic with occasional asynchronous resets
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 3; i++) begin
            dv[i]    = ($urandom_range(99) < 70);
            din_a[i] = $urandom;
         end
         if ($urandom_range(249) == 0) begin
            rst = 1'b0;
            tick(1 + $urandom_range(1));
            rst = 1'b1;
         end
         tick(1);
      end
      dv = 3'b000;
      tick(20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage sitting directly upstream of the 2-bit Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x_out, which drives the detector's x input.
- Supports configurable bit order and inter-word idle gap; flags word completion for upstream sequencing logic.

Parameters:
- WIDTH, 8, data bits per word (2..32)
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
- GAP, 0, idle bit-times inserted after each word (0..15)
- IDLE_LEVEL, 0, value driven on x_out when no bit is being sent

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- din  input  WIDTH  parallel word to serialize
- din_valid  input  1  din holds a word
- din_ready  output  1  feeder can accept a word this cycle
- x_out  output  1  serial bit to detector x input (registered)
- x_valid  output  1  x_out carries a data/parity bit this cycle (registered)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse coincident with final bit of a word (registered)

Behaviour:
- Reset (rst low, async): state=IDLE, x_out=IDLE_LEVEL, x_valid=0, done=0, bit counter=0, shift reg=0. din_ready is forced 0 while rst is low. First acceptance is possible on the first rising edge after rst deasserts.
- Handshake: transfer occurs on a rising edge with din_valid && din_ready. din is sampled only on that edge. din_valid without din_ready is held off, with no loss and no capture.
- States:
  - IDLE: din_ready=1. On transfer, load the shift reg and go to SHIFT.
  - SHIFT: on each edge, emit the next bit. After the last bit time, go to GAP if GAP>0. Otherwise go to IDLE, or reload and stay in SHIFT if a transfer occurs.
  - GAP: x_valid=0, x_out=IDLE_LEVEL for exactly GAP cycles, din_ready=0, then go to IDLE.
- Latency: first bit appears on x_out, with x_valid=1, in the cycle immediately following the transfer edge. Bits then follow on consecutive cycles with no bubbles. Total bit times per word is N (N=WIDTH, or WIDTH+1 with parity).
- Bit order: MSB_FIRST=1 emits din[WIDTH-1] down to din[0]. MSB_FIRST=0 emits din[0] up to din[WIDTH-1].
- din_ready in SHIFT: 1 only during the last bit time and only when GAP==0. A transfer there yields a back-to-back stream with x_valid continuously high and no IDLE_LEVEL bit between words.
- done: high for exactly the cycle in which the final bit (parity bit if enabled) is on x_out; 0 otherwise.
- Counter: log2-sized bit counter counts 0..N-1 and clears on reload. The GAP counter is separate, 4 bits.
- busy=1 in SHIFT and GAP, 0 in IDLE (including during reset).
- Reset mid-word: all outputs go to reset values immediately (async). The partial word is discarded and is not resumed.
- x_out and x_valid are flop outputs only; no combinational path from din/din_valid to them.

Optional Feature:
- Macro: SERIAL_BIT_FEEDER_PARITY_EN.
- Defined: an even-parity bit (XOR of all WIDTH data bits) is emitted as bit time N-1=WIDTH, after the data bits, with x_valid=1. done moves to the parity cycle. The back-to-back din_ready window moves to the parity cycle.
- Undefined: no parity logic is present and N=WIDTH.

Test Plan:
- Reset: hold rst=0 for 2 cycles with din_valid=1 -> x_out=0, x_valid=0, din_ready=0, busy=0, done=0. Release rst -> din_ready=1 next cycle, no transfer before release.
- Single word, WIDTH=8, MSB_FIRST=1, din=8'hA5 -> x_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after transfer. x_valid high for those 8 cycles, done high on the 8th, then x_valid=0 and din_ready=1.
- LSB-first, MSB_FIRST=0, din=8'h01 -> x_out = 1,0,0,0,0,0,0,0; busy high for exactly 8 cycles.
- Back-to-back, GAP=0: words 8'h0F then 8'hF0 with din_valid held -> 16 contiguous x_valid cycles. Sequence is 0000111111110000 (MSB_FIRST=1), exactly two done pulses, at cycles 8 and 16.
- GAP=2, two words queued -> 8 bits, then 2 cycles with x_valid=0, x_out=0, din_ready=0, then IDLE. The second word's first bit appears 3 cycles after the first word's last bit.
- Reset mid-word after 3 bits of 8'hFF -> x_valid=0 immediately, busy=0. After release, 8'h80 is serialized cleanly as 1 followed by 7 zeros. With SERIAL_BIT_FEEDER_PARITY_EN, 8'h07 gives 9 bit times, parity bit 1, done on the 9th.
